// File: rtl/seg_pattern_capture_if.sv
// Display-drive monitor bus: segment/select drive in, decoded digits out.
// SEG_CAPTURE_DP_EN adds the decimal-point input and per-digit dp output.
interface seg_pattern_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    upd_valid;
  logic [2:0]              upd_idx;
  logic                    err;
`ifdef SEG_CAPTURE_DP_EN
  logic                    seg_dp_n;
  logic [NUM_DIGITS-1:0]   dp;

  modport master (
    output seg_n, dig_sel, seg_dp_n,
    input  value, digit_valid, upd_valid,
    input  upd_idx, err, dp
  );
  modport slave (
    input  seg_n, dig_sel, seg_dp_n,
    output value, digit_valid, upd_valid,
    output upd_idx, err, dp
  );
`else
  modport master (
    output seg_n, dig_sel,
    input  value, digit_valid, upd_valid,
    input  upd_idx, err
  );
  modport slave (
    input  seg_n, dig_sel,
    output value, digit_valid, upd_valid,
    output upd_idx, err
  );
`endif
endinterface

// File: rtl/seg_pattern_capture.sv
// Debounces a multiplexed active-low 7-seg drive and decodes each digit.
// SEG_CAPTURE_DP_EN: also samples the decimal point and reports it per digit.
module seg_pattern_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input logic                  Clock,
  input logic                  Resetn,
  seg_pattern_capture_if.slave bus
);

`ifdef SEG_CAPTURE_DP_EN
  localparam int DPW = 1;
`else
  localparam int DPW = 0;
`endif
  localparam int SW = DPW + 7 + NUM_DIGITS;

  localparam logic [SW-1:0] SMP_RST =
    {{(DPW + 7){1'b1}}, {NUM_DIGITS{1'b0}}};
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]           cur;
  logic [SW-1:0]           smp_d, smp_q;
  logic [7:0]              cnt_d, cnt_q;
  logic [4*NUM_DIGITS-1:0] value_d, value_q;
  logic [NUM_DIGITS-1:0]   digit_valid_d, digit_valid_q;
  logic                    upd_valid_d, upd_valid_q;
  logic [2:0]              upd_idx_d, upd_idx_q;
  logic                    err_d, err_q;

  logic [6:0]              smp_seg;
  logic [NUM_DIGITS-1:0]   smp_sel;
  logic                    same;
  logic                    onehot;
  logic                    cap;
  logic                    blank;
  logic [4:0]              glyph;
  int                      idx;

`ifdef SEG_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0]   dp_d, dp_q;
  assign cur = {bus.seg_dp_n, bus.seg_n, bus.dig_sel};
`else
  assign cur = {bus.seg_n, bus.dig_sel};
`endif

  assign smp_seg = smp_q[NUM_DIGITS +: 7];
  assign smp_sel = smp_q[NUM_DIGITS-1:0];

  // {legal, hex} for one active-low glyph
  function automatic logic [4:0] dec(input logic [6:0] s);
    case (s)
      7'h40:   dec = {1'b1, 4'h0};
      7'h79:   dec = {1'b1, 4'h1};
      7'h24:   dec = {1'b1, 4'h2};
      7'h30:   dec = {1'b1, 4'h3};
      7'h19:   dec = {1'b1, 4'h4};
      7'h12:   dec = {1'b1, 4'h5};
      7'h02:   dec = {1'b1, 4'h6};
      7'h78:   dec = {1'b1, 4'h7};
      7'h00:   dec = {1'b1, 4'h8};
      7'h10:   dec = {1'b1, 4'h9};
      7'h08:   dec = {1'b1, 4'hA};
      7'h03:   dec = {1'b1, 4'hB};
      7'h46:   dec = {1'b1, 4'hC};
      7'h21:   dec = {1'b1, 4'hD};
      7'h06:   dec = {1'b1, 4'hE};
      7'h0E:   dec = {1'b1, 4'hF};
      default: dec = 5'h00;
    endcase
  endfunction

  // stability tracking and capture qualification
  always_comb begin
    smp_d  = cur;
    same   = (cur == smp_q);
    onehot = (smp_sel != '0) &&
             ((smp_sel & (smp_sel - NUM_DIGITS'(1))) == '0);
    if (!same)
      cnt_d = '0;
    else if (cnt_q >= CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 8'd1;
    cap = same && (cnt_q == CNT_CAP) && onehot;
    idx = 0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (smp_sel[i]) idx = i;
    glyph = dec(smp_seg);
    blank = (smp_seg == 7'h7F);
  end

  // per-digit result update on a capture
  always_comb begin
    value_d       = value_q;
    digit_valid_d = digit_valid_q;
    upd_valid_d   = 1'b0;
    upd_idx_d     = upd_idx_q;
    err_d         = 1'b0;
    if (cap) begin
      if (blank) begin
        digit_valid_d[idx] = 1'b0;
      end else if (glyph[4]) begin
        value_d[4*idx +: 4] = glyph[3:0];
        digit_valid_d[idx]  = 1'b1;
        upd_valid_d         = 1'b1;
        upd_idx_d           = 3'(idx);
      end else begin
        digit_valid_d[idx] = 1'b0;
        err_d              = 1'b1;
        upd_idx_d          = 3'(idx);
      end
    end
  end

  // state registers, synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      smp_q         <= SMP_RST;
      cnt_q         <= '0;
      value_q       <= '0;
      digit_valid_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_idx_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      smp_q         <= smp_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      digit_valid_q <= digit_valid_d;
      upd_valid_q   <= upd_valid_d;
      upd_idx_q     <= upd_idx_d;
      err_q         <= err_d;
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  // decimal point follows every capture, blank and illegal included
  always_comb begin
    dp_d = dp_q;
    if (cap) dp_d[idx] = ~smp_q[SW-1];
  end

  // decimal point register
  always_ff @(posedge Clock) begin
    if (!Resetn) dp_q <= '0;
    else         dp_q <= dp_d;
  end

  assign bus.dp = dp_q;
`endif

  assign bus.value       = value_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_idx     = upd_idx_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_seg_pattern_capture.sv
// Directed bench for seg_pattern_capture with a run-length reference model.
// Model compared every cycle; literal checks pin key scenarios.
module tb_seg_pattern_capture;
  localparam int ND = 4;
  localparam int S  = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  seg_pattern_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg_pattern_capture #(
    .NUM_DIGITS   (ND),
    .STABLE_CYCLES(S)
  ) dut (
    .Clock (clk),
    .Resetn(rstn),
    .bus   (bus)
  );

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // reference model: a capture happens when the same drive has been
  // seen S edges after it first appeared, with exactly one digit selected
  logic [6:0]    m_seg;
  logic [ND-1:0] m_sel;
  logic          m_dp;
  int            run;
  logic [3:0]    m_val [ND];
  logic [ND-1:0] m_dv;
  logic          m_upd, m_err;
  logic [2:0]    m_idx;

  always @(posedge clk) begin
    logic cur_dp;
    int   k, hv;
`ifdef SEG_CAPTURE_DP_EN
    cur_dp = bus.seg_dp_n;
`else
    cur_dp = 1'b1;
`endif
    if (!rstn) begin
      m_seg = 7'h7F; m_sel = '0; m_dp = 1'b1; run = 0;
      for (int i = 0; i < ND; i++) m_val[i] = 4'h0;
      m_dv = '0; m_upd = 1'b0; m_err = 1'b0; m_idx = '0;
    end else begin
      m_upd = 1'b0; m_err = 1'b0;
      if (bus.seg_n == m_seg && bus.dig_sel == m_sel && cur_dp == m_dp)
        run++;
      else begin
        run = 0; m_seg = bus.seg_n; m_sel = bus.dig_sel; m_dp = cur_dp;
      end
      if (run == S && $countones(m_sel) == 1) begin
        k = 0; hv = -1;
        for (int i = 0; i < ND; i++) if (m_sel[i]) k = i;
        for (int g = 0; g < 16; g++) if (glyph[g] == m_seg) hv = g;
        if (m_seg == 7'h7F) m_dv[k] = 1'b0;
        else if (hv >= 0) begin
          m_val[k] = 4'(hv); m_dv[k] = 1'b1; m_upd = 1'b1; m_idx = 3'(k);
        end else begin
          m_dv[k] = 1'b0; m_err = 1'b1; m_idx = 3'(k);
        end
      end
    end
  end

  bit chk_en     = 1'b0;
  int upd_seen   = 0;
  int err_seen   = 0;

  always @(negedge clk) begin
    logic [4*ND-1:0] ev;
    if (chk_en) begin
      for (int i = 0; i < ND; i++) ev[4*i +: 4] = m_val[i];
      chk("value", bus.value, ev);
      chk("digit_valid", bus.digit_valid, m_dv);
      chk("upd_valid", bus.upd_valid, m_upd);
      chk("err", bus.err, m_err);
      chk("upd_idx", bus.upd_idx, m_idx);
      if (bus.upd_valid) upd_seen++;
      if (bus.err) err_seen++;
    end
  end

  task automatic drive(logic [6:0] s, logic [ND-1:0] d);
    bus.seg_n   = s;
    bus.dig_sel = d;
  endtask

  task automatic hold(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int p0, e0, n;
`ifdef SEG_CAPTURE_DP_EN
    bus.seg_dp_n = 1'b1;
`endif
    drive(7'h7F, 4'b0000);
    rstn = 1'b0;
    hold(2);
    rstn   = 1'b1;
    chk_en = 1'b1;
    chk("rst_value", bus.value, 16'h0000);
    chk("rst_dv", bus.digit_valid, 4'b0000);
    chk("rst_upd", bus.upd_valid, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_idx", bus.upd_idx, 3'd0);

    drive(7'h24, 4'b0001);
    hold(8);
    chk("t1_early", bus.upd_valid, 1'b0);
    hold(1);
    chk("t1_val", bus.value[3:0], 4'h2);
    chk("t1_dv", bus.digit_valid, 4'b0001);
    chk("t1_upd", bus.upd_valid, 1'b1);
    chk("t1_idx", bus.upd_idx, 3'd0);
    hold(1);
    chk("t1_pulse", bus.upd_valid, 1'b0);
    p0 = upd_seen; e0 = err_seen;
    hold(30);
    chk("t1_norecap", 64'(upd_seen - p0), 0);
    chk("t1_noerr", 64'(err_seen - e0), 0);

    p0 = upd_seen;
    for (int g = 0; g < 16; g++) begin
      drive(glyph[g], 4'b1000);
      hold(9);
      chk("sweep_val", bus.value[15:12], 64'(g));
      chk("sweep_idx", bus.upd_idx, 3'd3);
      hold(1);
    end
    chk("sweep_cnt", 64'(upd_seen - p0), 16);
    chk("sweep_lo", bus.value[11:0], 12'h002);
    chk("sweep_dv", bus.digit_valid, 4'b1001);

    drive(7'h30, 4'b0010);
    hold(10);
    chk("d1_val", bus.value[7:4], 4'h3);
    chk("d1_dv", bus.digit_valid[1], 1'b1);
    e0 = err_seen;
    drive(7'h55, 4'b0010);
    hold(9);
    chk("ill_err", bus.err, 1'b1);
    chk("ill_idx", bus.upd_idx, 3'd1);
    hold(1);
    chk("ill_cnt", 64'(err_seen - e0), 1);
    chk("ill_dv", bus.digit_valid[1], 1'b0);
    chk("ill_val", bus.value[7:4], 4'h3);

    p0 = upd_seen; e0 = err_seen;
    drive(7'h7F, 4'b0001);
    hold(10);
    chk("blank_dv", bus.digit_valid[0], 1'b0);
    chk("blank_val", bus.value[3:0], 4'h2);
    chk("blank_upd", 64'(upd_seen - p0), 0);
    chk("blank_err", 64'(err_seen - e0), 0);

    p0 = upd_seen; e0 = err_seen;
    repeat (6) begin
      drive(7'h12, 4'b0100); hold(4);
      drive(7'h02, 4'b0100); hold(4);
    end
    drive(7'h19, 4'b0100); hold(8);
    drive(7'h12, 4'b0100); hold(8);
    drive(7'h24, 4'b0011); hold(20);
    drive(7'h24, 4'b0000); hold(12);
    chk("noise_upd", 64'(upd_seen - p0), 0);
    chk("noise_err", 64'(err_seen - e0), 0);

    drive(7'h19, 4'b0001);
    hold(6);
    rstn = 1'b0;
    hold(1);
    chk("mrst_value", bus.value, 16'h0000);
    chk("mrst_dv", bus.digit_valid, 4'b0000);
    chk("mrst_idx", bus.upd_idx, 3'd0);
    chk("mrst_flags", {bus.upd_valid, bus.err}, 2'b00);
    rstn = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #2;
      if (bus.upd_valid) begin
        n = i;
        break;
      end
    end
    chk("cap_after_rst", 64'(n), 9);
    chk("mrst_cap_val", bus.value[3:0], 4'h4);

    hold(3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
